// File: rtl/syncram_banked.sv
// -----------------------------------------------------------------------------
// syncram_banked
//   Dual-port, byte-writable synchronous RAM split into NBANKS interleaved banks
//   (bank = low address bits, row = remaining high bits). Accesses to different
//   banks proceed in parallel. Two requests to the same bank are arbitrated by a
//   one-bit priority flag that flips to the losing port after every conflict, so
//   continuous contention alternates grants. A stalled port must hold its request.
//
// Ports
//   clk                 sole clock, rising edge
//   rst                 synchronous, active-high reset
//   ren_x / wen_x       read / write request for port x (a or b)
//   addr_x [AW]         word address
//   wdata_x [WORD_W]    store data
//   be_x [BW]           byte enables, bit i covers bits [8i+7:8i]
//   ready_x             request accepted this cycle (combinational)
//   rvalid_x            one-cycle pulse, rdata_x valid
//   rdata_x [WORD_W]    load data, holds its value between pulses
// -----------------------------------------------------------------------------
module syncram_banked #(
  parameter int WORD_W   = 32,
  parameter int DEPTH    = 1024,
  parameter int NBANKS   = 4,
  parameter int RDW_MODE = 0,
  localparam int AW      = $clog2(DEPTH),
  localparam int BW      = WORD_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ren_a,
  input  logic              wen_a,
  input  logic [AW-1:0]     addr_a,
  input  logic [WORD_W-1:0] wdata_a,
  input  logic [BW-1:0]     be_a,
  input  logic              ren_b,
  input  logic              wen_b,
  input  logic [AW-1:0]     addr_b,
  input  logic [WORD_W-1:0] wdata_b,
  input  logic [BW-1:0]     be_b,
  output logic              ready_a,
  output logic              ready_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  output logic [WORD_W-1:0] rdata_a,
  output logic [WORD_W-1:0] rdata_b
);

  localparam int KB   = $clog2(NBANKS);
  localparam int KBW  = (KB > 0) ? KB : 1;          // bank index width, >= 1
  localparam int RWW  = (AW - KB > 0) ? AW - KB : 1; // row index width, >= 1
  localparam int ROWS = DEPTH / NBANKS;

  logic [WORD_W-1:0] mem [NBANKS][ROWS];

  logic [KBW-1:0] bank_a, bank_b;
  logic [RWW-1:0] row_a, row_b;
  logic           req_a, req_b, conflict, pri;
  logic           acc_a, acc_b;

  // Masking with NBANKS-1 yields bank 0 for the single-bank case.
  assign bank_a = KBW'(addr_a & AW'(NBANKS - 1));
  assign bank_b = KBW'(addr_b & AW'(NBANKS - 1));
  assign row_a  = RWW'(addr_a >> KB);
  assign row_b  = RWW'(addr_b >> KB);

  assign req_a    = ren_a | wen_a;
  assign req_b    = ren_b | wen_b;
  assign conflict = req_a & req_b & (bank_a == bank_b);

  // An idle port reports ready; during reset nothing is accepted.
  assign ready_a = ~rst & (~conflict | ~pri);
  assign ready_b = ~rst & (~conflict |  pri);
  assign acc_a   = req_a & ready_a;
  assign acc_b   = req_b & ready_b;

  // Word as seen by a read that coincides with a write on the same port.
  function automatic logic [WORD_W-1:0] rd_word(input logic [WORD_W-1:0] old_w,
                                                input logic [WORD_W-1:0] new_w,
                                                input logic [BW-1:0]     be,
                                                input logic              wen);
    logic [WORD_W-1:0] w;
    w = old_w;
    if (RDW_MODE != 0 && wen) begin
      for (int i = 0; i < BW; i++) begin
        if (be[i]) w[8*i +: 8] = new_w[8*i +: 8];
      end
    end
    return w;
  endfunction

  // NOTE: the storage array has no reset branch; contents survive reset and a
  // reset-free array maps onto RAM macros instead of flops.
  // Accepted ports never share a bank, so the two writes never collide.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BW; i++) begin
      if (acc_a && wen_a && be_a[i]) mem[bank_a][row_a][8*i +: 8] <= wdata_a[8*i +: 8];
      if (acc_b && wen_b && be_b[i]) mem[bank_b][row_b][8*i +: 8] <= wdata_b[8*i +: 8];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, which also gives old-data reads for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
      rdata_a  <= '0;
      rdata_b  <= '0;
      pri      <= 1'b0;
    end else begin
      rvalid_a <= acc_a & ren_a;
      rvalid_b <= acc_b & ren_b;
      if (acc_a && ren_a) rdata_a <= rd_word(mem[bank_a][row_a], wdata_a, be_a, wen_a);
      if (acc_b && ren_b) rdata_b <= rd_word(mem[bank_b][row_b], wdata_b, be_b, wen_b);
      // Priority moves to whichever port just lost.
      if (conflict) pri <= ~pri;
    end
  end

endmodule

// File: doc/syncram_banked.md
SYNCRAM_BANKED -- requirements
Module: syncram_banked

Interface
REQ-001 Parameter WORD_W, default 32, data word width in bits, multiple of 8.
REQ-002 Parameter DEPTH, default 1024, total words, power of two.
REQ-003 Parameter NBANKS, default 4, bank count, power of two, 1 <= NBANKS <= DEPTH.
REQ-004 Parameter RDW_MODE, default 0, same-port read-during-write: 0 = old data, 1 = new data.
REQ-005 Derived: AW = log2(DEPTH), BW = WORD_W/8, KB = log2(NBANKS).
REQ-006 clk  in  1  sole clock; all state changes on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 ren_a, ren_b  in  1  read request, per port.
REQ-009 wen_a, wen_b  in  1  write request, per port.
REQ-010 addr_a, addr_b  in  AW  word address.
REQ-011 wdata_a, wdata_b  in  WORD_W  store data.
REQ-012 be_a, be_b  in  BW  byte write enables; bit i covers bits [8i+7:8i].
REQ-013 ready_a, ready_b  out  1  request accepted this cycle (combinational).
REQ-014 rvalid_a, rvalid_b  out  1  rdata valid, one-cycle pulse.
REQ-015 rdata_a, rdata_b  out  WORD_W  load data.

Function
REQ-016 Port x requests when ren_x | wen_x; bank = addr_x[KB-1:0], row = addr_x >> KB.
REQ-017 Idle port drives ready_x = 1; no access occurs.
REQ-018 Both ports request, different banks: both ready = 1, both accesses in the same cycle.
REQ-019 Both ports request, same bank: only the port selected by priority flag pri gets ready = 1; the other gets ready = 0 and no access.
REQ-020 pri = 0 favours A, pri = 1 favours B; on a conflict cycle pri <= loser; otherwise pri holds.
REQ-021 A stalled port holds its request and operands until ready; the block does not latch unaccepted requests.
REQ-022 Accepted write: at the clock edge, only bytes with be set are updated at (bank, row); be = 0 writes nothing.
REQ-023 Accepted read: rvalid_x = 1 in the following cycle only, with rdata_x = word at address.
REQ-024 rdata_x holds its last value while rvalid_x = 0.
REQ-025 ren_x and wen_x both high: the write is performed; rdata_x returns the pre-write word if RDW_MODE = 0, or the byte-merged post-write word if RDW_MODE = 1.
REQ-026 Cross-port same-address access in one cycle is impossible (same bank, REQ-019); results are fully deterministic.
REQ-027 NBANKS = 1: every two-port cycle conflicts; under continuous requests grants alternate A, B, A, B.
REQ-028 Back-to-back accepted reads on one port yield rvalid every cycle; throughput is 1 access/port/cycle.

Reset
REQ-029 While rst = 1: ready_a = ready_b = 0, no memory writes, no reads accepted.
REQ-030 Clock edge with rst = 1: rvalid_a, rvalid_b <= 0; rdata_a, rdata_b <= 0; pri <= 0.
REQ-031 Memory contents are not reset; they retain values across reset.
REQ-032 A read accepted at the edge before rst rises still produces its rvalid pulse; a request presented during rst = 1 is dropped.

Verification
REQ-033 Reset, then write A addr 3 = 555 (0x22B), be = all ones; read A addr 3 -> next cycle rvalid_a = 1, rdata_a = 0x0000022B.
REQ-034 NBANKS = 4, pri = 0: A reads addr 1 and B reads addr 5 together -> cycle 1: ready_a = 1, ready_b = 0; cycle 2 (B held, A idle or still requesting bank 1): ready_b = 1; rdata_b follows in cycle 3.
REQ-035 Simultaneous writes A addr 2 = 0x11, B addr 3 = 0x22 -> both ready = 1; subsequent reads return 0x11 and 0x22.
REQ-036 Addr 4 = 0xAABBCCDD, then write 0x11223344 with be = 4'b0101 -> read returns 0xAA22CC44.
REQ-037 Addr 7 = 0x1; ren & wen on A, wdata 0x2 -> rdata_a = 0x1 with RDW_MODE = 0, 0x2 with RDW_MODE = 1; a later read returns 0x2 in both modes.
REQ-038 Write request with rst = 1 -> ready = 0, no rvalid, memory unchanged on later read.
